// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_register_file
// Brief    : Write-back stage and 32-entry architectural register file.
//            Selects the write-back value from MEM/WB, commits it on the
//            rising edge, serves two combinational read ports with
//            write-to-read bypass, and keeps a retired-write counter and a
//            last-write trace for debug.
// Revision : 1.0 - initial release
// ============================================================================
module wb_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,          // asynchronous, active-low
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [ADDR_WIDTH-1:0] reg_rd_in,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  output logic [31:0]           write_count,
  output logic [ADDR_WIDTH-1:0] last_wr_addr,
  output logic [DATA_WIDTH-1:0] last_wr_data
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [31:0]           r_write_count;
  logic [ADDR_WIDTH-1:0] r_last_wr_addr;
  logic [DATA_WIDTH-1:0] r_last_wr_data;

  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_commit;
  logic                  w_bypass_en;

  // Write-back value select; valid whether or not a write is enabled.
  always_comb begin
    w_wb_data = mem_to_reg_in ? read_data_in : alu_result_in;
  end

  // Commit qualifies the write; bypass is additionally suppressed during
  // reset so the read ports return zero while reset is held.
  always_comb begin
    w_commit    = reg_write_in && (reg_rd_in != '0);
    w_bypass_en = w_commit && reset;
  end

  // Storage, retired-write counter and last-write trace.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_write_count  <= '0;
      r_last_wr_addr <= '0;
      r_last_wr_data <= '0;
    end else if (w_commit) begin
      r_regs[reg_rd_in] <= w_wb_data;
      r_write_count     <= r_write_count + 32'd1;
      r_last_wr_addr    <= reg_rd_in;
      r_last_wr_data    <= w_wb_data;
    end
  end

  // Read port 1: x0 hardwired to zero, then bypass, then storage.
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (w_bypass_en && (rs1_addr == reg_rd_in)) begin
      rs1_data = w_wb_data;
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (w_bypass_en && (rs2_addr == reg_rd_in)) begin
      rs2_data = w_wb_data;
    end
  end

  // Output wiring.
  always_comb begin
    wb_data_out  = w_wb_data;
    write_count  = r_write_count;
    last_wr_addr = r_last_wr_addr;
    last_wr_data = r_last_wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_register_file
// Brief    : Directed self-checking bench for wb_register_file. Inputs are
//            driven on the falling edge, as the MEM/WB register would.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_register_file;

  logic        clock;
  logic        reset;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  reg_rd_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data_out;
  logic [31:0] write_count;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  int n_vec;
  int n_miss;

  wb_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_to_reg_in (mem_to_reg_in),
    .reg_write_in  (reg_write_in),
    .read_data_in  (read_data_in),
    .alu_result_in (alu_result_in),
    .reg_rd_in     (reg_rd_in),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_data_out   (wb_data_out),
    .write_count   (write_count),
    .last_wr_addr  (last_wr_addr),
    .last_wr_data  (last_wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
    read_data_in = '0; alu_result_in = '0; reg_rd_in = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd31;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL reset_rs1 got %h exp %h", rs1_data, 32'd0); end
    n_vec++; if (rs2_data !== 32'd0) begin n_miss++; $display("FAIL reset_rs2 got %h exp %h", rs2_data, 32'd0); end
    n_vec++; if (write_count !== 32'd0) begin n_miss++; $display("FAIL reset_count got %0d exp 0", write_count); end
    n_vec++; if (last_wr_addr !== 5'd0) begin n_miss++; $display("FAIL reset_last_addr got %0d exp 0", last_wr_addr); end
    n_vec++; if (last_wr_data !== 32'd0) begin n_miss++; $display("FAIL reset_last_data got %h exp 0", last_wr_data); end
  endtask

  task automatic test_alu_bypass();
    @(negedge clock);
    mem_to_reg_in = 1'b0; reg_write_in = 1'b1; reg_rd_in = 5'd7;
    alu_result_in = 32'h0000_1234; read_data_in = 32'hDEAD_BEEF; rs1_addr = 5'd7;
    #1;
    n_vec++; if (wb_data_out !== 32'h1234) begin n_miss++; $display("FAIL alu_wbdata got %h exp %h", wb_data_out, 32'h1234); end
    n_vec++; if (rs1_data !== 32'h1234) begin n_miss++; $display("FAIL alu_bypass got %h exp %h", rs1_data, 32'h1234); end
    @(posedge clock); #1;
    reg_write_in = 1'b0;
    #1;
    n_vec++; if (rs1_data !== 32'h1234) begin n_miss++; $display("FAIL alu_storage got %h exp %h", rs1_data, 32'h1234); end
    n_vec++; if (write_count !== 32'd1) begin n_miss++; $display("FAIL alu_count got %0d exp 1", write_count); end
    n_vec++; if (last_wr_addr !== 5'd7) begin n_miss++; $display("FAIL alu_last_addr got %0d exp 7", last_wr_addr); end
    n_vec++; if (last_wr_data !== 32'h1234) begin n_miss++; $display("FAIL alu_last_data got %h exp %h", last_wr_data, 32'h1234); end
  endtask

  task automatic test_load();
    @(negedge clock);
    mem_to_reg_in = 1'b1; reg_write_in = 1'b1; reg_rd_in = 5'd12;
    read_data_in = 32'hCAFE_F00D; alu_result_in = 32'h0000_0BAD;
    rs1_addr = 5'd7; rs2_addr = 5'd12;
    #1;
    n_vec++; if (wb_data_out !== 32'hCAFEF00D) begin n_miss++; $display("FAIL load_wbdata got %h exp %h", wb_data_out, 32'hCAFEF00D); end
    @(posedge clock); #1;
    reg_write_in = 1'b0;
    #1;
    n_vec++; if (rs2_data !== 32'hCAFEF00D) begin n_miss++; $display("FAIL load_rs2 got %h exp %h", rs2_data, 32'hCAFEF00D); end
    n_vec++; if (rs1_data !== 32'h1234) begin n_miss++; $display("FAIL load_rs1_x7 got %h exp %h", rs1_data, 32'h1234); end
    n_vec++; if (write_count !== 32'd2) begin n_miss++; $display("FAIL load_count got %0d exp 2", write_count); end
  endtask

  task automatic test_x0_protect();
    @(negedge clock);
    mem_to_reg_in = 1'b0; reg_write_in = 1'b1; reg_rd_in = 5'd0;
    alu_result_in = 32'hFFFF_FFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL x0_bypass got %h exp 0", rs1_data); end
    repeat (3) @(posedge clock);
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL x0_rs1 got %h exp 0", rs1_data); end
    n_vec++; if (rs2_data !== 32'd0) begin n_miss++; $display("FAIL x0_rs2 got %h exp 0", rs2_data); end
    n_vec++; if (write_count !== 32'd2) begin n_miss++; $display("FAIL x0_count got %0d exp 2", write_count); end
    n_vec++; if (last_wr_addr !== 5'd12) begin n_miss++; $display("FAIL x0_last_addr got %0d exp 12", last_wr_addr); end
    n_vec++; if (last_wr_data !== 32'hCAFEF00D) begin n_miss++; $display("FAIL x0_last_data got %h exp %h", last_wr_data, 32'hCAFEF00D); end
    reg_write_in = 1'b0;
  endtask

  task automatic test_write_disabled();
    @(negedge clock);
    mem_to_reg_in = 1'b0; reg_write_in = 1'b0; reg_rd_in = 5'd3;
    alu_result_in = 32'h55; rs1_addr = 5'd3;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL nowr_bypass got %h exp 0", rs1_data); end
    @(posedge clock); #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL nowr_storage got %h exp 0", rs1_data); end
    n_vec++; if (write_count !== 32'd2) begin n_miss++; $display("FAIL nowr_count got %0d exp 2", write_count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    mem_to_reg_in = 1'b0; reg_write_in = 1'b1; reg_rd_in = 5'd20;
    alu_result_in = 32'h2020_2020; rs1_addr = 5'd20; rs2_addr = 5'd20;
    #1;
    n_vec++; if (rs1_data !== 32'h20202020) begin n_miss++; $display("FAIL b2b_rs1_bypass got %h exp %h", rs1_data, 32'h20202020); end
    n_vec++; if (rs2_data !== 32'h20202020) begin n_miss++; $display("FAIL b2b_rs2_bypass got %h exp %h", rs2_data, 32'h20202020); end
    @(negedge clock);
    reg_rd_in = 5'd21; alu_result_in = 32'h2121_2121; rs2_addr = 5'd21;
    #1;
    n_vec++; if (rs1_data !== 32'h20202020) begin n_miss++; $display("FAIL b2b_rs1_storage got %h exp %h", rs1_data, 32'h20202020); end
    n_vec++; if (rs2_data !== 32'h21212121) begin n_miss++; $display("FAIL b2b_rs2_bypass2 got %h exp %h", rs2_data, 32'h21212121); end
    @(posedge clock); #1;
    reg_write_in = 1'b0;
    #1;
    n_vec++; if (rs2_data !== 32'h21212121) begin n_miss++; $display("FAIL b2b_rs2_storage got %h exp %h", rs2_data, 32'h21212121); end
    n_vec++; if (write_count !== 32'd4) begin n_miss++; $display("FAIL b2b_count got %0d exp 4", write_count); end
    n_vec++; if (last_wr_addr !== 5'd21) begin n_miss++; $display("FAIL b2b_last_addr got %0d exp 21", last_wr_addr); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    mem_to_reg_in = 1'b0; reg_write_in = 1'b1; reg_rd_in = 5'd9;
    alu_result_in = 32'hA5A5_A5A5; rs1_addr = 5'd9; rs2_addr = 5'd12;
    @(posedge clock); #1;
    n_vec++; if (write_count !== 32'd5) begin n_miss++; $display("FAIL mid_pre_count got %0d exp 5", write_count); end
    @(negedge clock);
    alu_result_in = 32'h1111;
    #1;
    reset = 1'b0;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL mid_rs1_now got %h exp 0", rs1_data); end
    n_vec++; if (rs2_data !== 32'd0) begin n_miss++; $display("FAIL mid_rs2_now got %h exp 0", rs2_data); end
    n_vec++; if (write_count !== 32'd0) begin n_miss++; $display("FAIL mid_count_now got %0d exp 0", write_count); end
    n_vec++; if (last_wr_addr !== 5'd0) begin n_miss++; $display("FAIL mid_last_addr got %0d exp 0", last_wr_addr); end
    n_vec++; if (last_wr_data !== 32'd0) begin n_miss++; $display("FAIL mid_last_data got %h exp 0", last_wr_data); end
    @(posedge clock); #1;
    n_vec++; if (write_count !== 32'd0) begin n_miss++; $display("FAIL mid_count_edge got %0d exp 0", write_count); end
    @(negedge clock);
    reg_write_in = 1'b0; reset = 1'b1;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_miss++; $display("FAIL mid_x9_after got %h exp 0", rs1_data); end
    n_vec++; if (write_count !== 32'd0) begin n_miss++; $display("FAIL mid_count_after got %0d exp 0", write_count); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_alu_bypass();
    test_load();
    test_x0_protect();
    test_write_disabled();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
